ips2l_pcie_dma_mwr_tlp_sched: RTL and testbench

Memory-write TLP scheduler for the PCIe DMA controller. It accepts one DMA write job (host address plus total DW count) and splits it into a sequence of MWr TLPs. Each TLP respects the configured max payload size and never crosses a 4 KB host-address boundary. For every TLP it drives a request/length/address to the downstream MWr read-control/TLP-generation path, then waits for that TLP's last data beat before issuing the next.

---
 rtl/ips2l_pcie_dma_mwr_tlp_sched.sv | 126 ++++++++++++
 tb/tb_ips2l_pcie_dma_mwr_tlp_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ips2l_pcie_dma_mwr_tlp_sched.sv
// Splits one DMA write job into MWr TLPs bounded by max payload size and 4 KB host pages.
// Latency: start -> o_tlp_req in 2 cycles; i_tlp_last -> next o_tlp_req in 3 cycles, or -> o_dma_done in 2 cycles.
// Backpressure: each TLP holds o_tlp_req/addr/length until i_tlp_last; no new job is accepted while busy.
//
// Ports: clk/rst_n (async active-low); i_dma_start/i_dma_addr/i_dma_len job request;
//        i_cfg_mps max payload select; i_dma_abort cancels the job; i_tlp_last ends the current TLP;
//        o_tlp_req/o_tlp_addr/o_tlp_length per-TLP request; o_dma_busy/o_dma_done/o_tlp_cnt job status.
module ips2l_pcie_dma_mwr_tlp_sched #(
    parameter int LEN_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_dma_start,
    input  logic [63:0]          i_dma_addr,
    input  logic [LEN_WIDTH-1:0] i_dma_len,
    input  logic [2:0]           i_cfg_mps,
    input  logic                 i_dma_abort,
    input  logic                 i_tlp_last,
    output logic                 o_tlp_req,
    output logic [63:0]          o_tlp_addr,
    output logic [9:0]           o_tlp_length,
    output logic                 o_dma_busy,
    output logic                 o_dma_done,
    output logic [15:0]          o_tlp_cnt
);

    typedef enum logic [2:0] {IDLE, CALC, REQ, GAP, DONE} state_t;

    // Comparison width wide enough for both the remaining count and an 11-bit page distance.
    localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

    state_t               state;
    logic [63:0]          addr_r;
    logic [LEN_WIDTH-1:0] rem_r;

    logic [10:0]          mps_dw;
    logic [10:0]          dw_to_4k;
    logic [10:0]          cand;
    logic [CW-1:0]        rem_ext;
    logic [9:0]           tlp_len_nxt;

    // Next TLP length = min(remaining, mps, distance to the next 4 KB page).
    always_comb begin
        case (i_cfg_mps)
            3'b000:  mps_dw = 11'd32;
            3'b001:  mps_dw = 11'd64;
            default: mps_dw = 11'd128;
        endcase
        dw_to_4k = 11'd1024 - {1'b0, addr_r[11:2]};
        cand     = mps_dw;
        if (dw_to_4k < cand) begin
            cand = dw_to_4k;
        end
        rem_ext = CW'(rem_r);
        // Only taken when rem_r < cand <= 128, so the low bits hold the whole value.
        if (rem_ext < CW'(cand)) begin
            cand = rem_ext[10:0];
        end
        tlp_len_nxt = cand[9:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_r       <= '0;
            rem_r        <= '0;
            o_tlp_req    <= 1'b0;
            o_tlp_addr   <= '0;
            o_tlp_length <= '0;
            o_dma_busy   <= 1'b0;
            o_dma_done   <= 1'b0;
            o_tlp_cnt    <= '0;
        end else if (i_dma_abort && state != IDLE) begin
            // Abort wins over a coincident i_tlp_last; the TLP count is left as-is.
            state      <= IDLE;
            o_tlp_req  <= 1'b0;
            o_dma_busy <= 1'b0;
            o_dma_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_dma_start && i_dma_len != '0) begin
                        addr_r     <= i_dma_addr & ~64'h3;
                        rem_r      <= i_dma_len;
                        o_tlp_cnt  <= '0;
                        o_dma_busy <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    o_tlp_length <= tlp_len_nxt;
                    o_tlp_addr   <= addr_r;
                    o_tlp_req    <= 1'b1;
                    state        <= REQ;
                end
                REQ: begin
                    if (i_tlp_last) begin
                        addr_r    <= addr_r + {52'd0, o_tlp_length, 2'b00};
                        rem_r     <= rem_r - LEN_WIDTH'(o_tlp_length);
                        o_tlp_cnt <= o_tlp_cnt + 16'd1;
                        o_tlp_req <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // One idle cycle so every TLP gets its own rising edge of o_tlp_req.
                    if (rem_r == '0) begin
                        o_dma_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                DONE: begin
                    o_dma_done <= 1'b0;
                    o_dma_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ips2l_pcie_dma_mwr_tlp_sched.sv
module tb_ips2l_pcie_dma_mwr_tlp_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_start;
    logic [63:0] dma_addr;
    logic [19:0] dma_len;
    logic [2:0]  cfg_mps;
    logic        dma_abort;
    logic        tlp_last;
    logic        tlp_req;
    logic [63:0] tlp_addr;
    logic [9:0]  tlp_length;
    logic        dma_busy;
    logic        dma_done;
    logic [15:0] tlp_cnt;

    int total = 0;
    int bad   = 0;

    ips2l_pcie_dma_mwr_tlp_sched #(.LEN_WIDTH(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dma_start  (dma_start),
        .i_dma_addr   (dma_addr),
        .i_dma_len    (dma_len),
        .i_cfg_mps    (cfg_mps),
        .i_dma_abort  (dma_abort),
        .i_tlp_last   (tlp_last),
        .o_tlp_req    (tlp_req),
        .o_tlp_addr   (tlp_addr),
        .o_tlp_length (tlp_length),
        .o_dma_busy   (dma_busy),
        .o_dma_done   (dma_done),
        .o_tlp_cnt    (tlp_cnt)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle; returns at the falling edge right after the sampling edge.
    task automatic start_job(input logic [63:0] a, input logic [19:0] l);
        @(negedge clk);
        dma_start = 1'b1;
        dma_addr  = a;
        dma_len   = l;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    // Wait (bounded) for a request, capture it, hold one cycle, then return its last beat.
    task automatic serve_tlp(output logic [63:0] a, output logic [9:0] l, output bit ok);
        ok = 1'b0;
        a  = '0;
        l  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (tlp_req) ok = 1'b1;
        end
        if (ok) begin
            a = tlp_addr;
            l = tlp_length;
            @(negedge clk);
            tlp_last = 1'b1;
            @(negedge clk);
            tlp_last = 1'b0;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (dma_done) n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tlp_req, dma_busy, dma_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got req/busy/done=%b required 000", {tlp_req, dma_busy, dma_done});
        end
        total++;
        if (tlp_addr !== 64'h0 || tlp_length !== 10'd0) begin
            bad++;
            $display("FAIL reset_addr_len: got addr=%h len=%0d required 0/0", tlp_addr, tlp_length);
        end
        total++;
        if (tlp_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d required 0", tlp_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mps32;
        logic [63:0] ea [4];
        logic [9:0]  el [4];
        logic [63:0] a;
        logic [9:0]  l;
        bit          ok;
        int          n;
        ea[0] = 64'h1000; ea[1] = 64'h1080; ea[2] = 64'h1100; ea[3] = 64'h1180;
        el[0] = 10'd32;   el[1] = 10'd32;   el[2] = 10'd32;   el[3] = 10'd4;
        cfg_mps = 3'b000;
        start_job(64'h1000, 20'd100);
        for (int k = 0; k < 4; k++) begin
            serve_tlp(a, l, ok);
            total++;
            if (!ok || a !== ea[k] || l !== el[k]) begin
                bad++;
                $display("FAIL mps32_tlp%0d: got ok=%0d addr=%h len=%0d required addr=%h len=%0d",
                         k, ok, a, l, ea[k], el[k]);
            end
        end
        count_done(5, n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL mps32_done: got %0d pulses required 1", n);
        end
        total++;
        if (tlp_cnt !== 16'd4 || dma_busy !== 1'b0) begin
            bad++;
            $display("FAIL mps32_cnt: got cnt=%0d busy=%b required cnt=4 busy=0", tlp_cnt, dma_busy);
        end
    endtask

    task automatic test_4k_split;
        logic [63:0] a;
        logic [9:0]  l;
        bit          ok;
        int          n;
        cfg_mps = 3'b010;
        start_job(64'h0FF0, 20'd10);
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h0FF0 || l !== 10'd4) begin
            bad++;
            $display("FAIL split_tlp0: got ok=%0d addr=%h len=%0d required addr=0ff0 len=4", ok, a, l);
        end
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h1000 || l !== 10'd6) begin
            bad++;
            $display("FAIL split_tlp1: got ok=%0d addr=%h len=%0d required addr=1000 len=6", ok, a, l);
        end
        count_done(5, n);
        total++;
        if (n != 1 || tlp_cnt !== 16'd2) begin
            bad++;
            $display("FAIL split_done: got done=%0d cnt=%0d required 1/2", n, tlp_cnt);
        end
    endtask

    task automatic test_latency;
        start_job(64'h3, 20'd1);
        total++;
        if (dma_busy !== 1'b1 || tlp_req !== 1'b0) begin
            bad++;
            $display("FAIL lat_calc: got busy=%b req=%b required 1/0", dma_busy, tlp_req);
        end
        @(negedge clk);
        total++;
        if (tlp_req !== 1'b1 || tlp_addr !== 64'h0 || tlp_length !== 10'd1) begin
            bad++;
            $display("FAIL lat_req: got req=%b addr=%h len=%0d required 1/0/1", tlp_req, tlp_addr, tlp_length);
        end
        tlp_last = 1'b1;
        @(negedge clk);
        tlp_last = 1'b0;
        total++;
        if (tlp_req !== 1'b0 || dma_done !== 1'b0) begin
            bad++;
            $display("FAIL lat_gap: got req=%b done=%b required 0/0", tlp_req, dma_done);
        end
        @(negedge clk);
        total++;
        if (dma_done !== 1'b1 || dma_busy !== 1'b1) begin
            bad++;
            $display("FAIL lat_done: got done=%b busy=%b required 1/1", dma_done, dma_busy);
        end
        @(negedge clk);
        total++;
        if (dma_done !== 1'b0 || dma_busy !== 1'b0 || tlp_cnt !== 16'd1) begin
            bad++;
            $display("FAIL lat_idle: got done=%b busy=%b cnt=%0d required 0/0/1", dma_done, dma_busy, tlp_cnt);
        end
    endtask

    task automatic test_ignored_starts;
        logic [63:0] a;
        logic [9:0]  l;
        bit          ok;
        bit          seen;
        int          n;
        start_job(64'h9000, 20'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dma_busy || tlp_req || dma_done) seen = 1'b1;
        end
        total++;
        if (seen || tlp_cnt !== 16'd1) begin
            bad++;
            $display("FAIL zero_len: got activity=%0d cnt=%0d required 0/1", seen, tlp_cnt);
        end
        cfg_mps = 3'b000;
        start_job(64'h2000, 20'd40);
        dma_start = 1'b1;
        dma_addr  = 64'h7000;
        dma_len   = 20'd3;
        @(negedge clk);
        dma_start = 1'b0;
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h2000 || l !== 10'd32) begin
            bad++;
            $display("FAIL busy_start_tlp0: got ok=%0d addr=%h len=%0d required 2000/32", ok, a, l);
        end
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h2080 || l !== 10'd8) begin
            bad++;
            $display("FAIL busy_start_tlp1: got ok=%0d addr=%h len=%0d required 2080/8", ok, a, l);
        end
        count_done(6, n);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (tlp_req || dma_busy) seen = 1'b1;
        end
        total++;
        if (n != 1 || seen || tlp_cnt !== 16'd2) begin
            bad++;
            $display("FAIL busy_start_end: got done=%0d extra=%0d cnt=%0d required 1/0/2", n, seen, tlp_cnt);
        end
    endtask

    task automatic test_abort;
        logic [63:0] a;
        logic [9:0]  l;
        bit          ok;
        int          n;
        cfg_mps = 3'b000;
        start_job(64'h3000, 20'd96);
        serve_tlp(a, l, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (tlp_req) ok = 1'b1;
        end
        total++;
        if (!ok || tlp_addr !== 64'h3080) begin
            bad++;
            $display("FAIL abort_second_req: got ok=%0d addr=%h required 1/3080", ok, tlp_addr);
        end
        dma_abort = 1'b1;
        tlp_last  = 1'b1;
        @(negedge clk);
        dma_abort = 1'b0;
        tlp_last  = 1'b0;
        total++;
        if (tlp_req !== 1'b0 || dma_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop: got req=%b busy=%b required 0/0", tlp_req, dma_busy);
        end
        count_done(5, n);
        total++;
        if (n != 0 || tlp_cnt !== 16'd1 || tlp_req !== 1'b0) begin
            bad++;
            $display("FAIL abort_after: got done=%0d cnt=%0d req=%b required 0/1/0", n, tlp_cnt, tlp_req);
        end
        cfg_mps = 3'b010;
        start_job(64'h5000, 20'd5);
        serve_tlp(a, l, ok);
        count_done(5, n);
        total++;
        if (!ok || a !== 64'h5000 || l !== 10'd5 || n != 1 || tlp_cnt !== 16'd1) begin
            bad++;
            $display("FAIL abort_restart: got ok=%0d addr=%h len=%0d done=%0d cnt=%0d required 5000/5/1/1",
                     ok, a, l, n, tlp_cnt);
        end
    endtask

    task automatic test_carry;
        logic [63:0] a;
        logic [9:0]  l;
        bit          ok;
        int          n;
        cfg_mps = 3'b001;
        start_job(64'h0000_0000_FFFF_FFC0, 20'd64);
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h0000_0000_FFFF_FFC0 || l !== 10'd16) begin
            bad++;
            $display("FAIL carry_tlp0: got ok=%0d addr=%h len=%0d required ffffffc0/16", ok, a, l);
        end
        serve_tlp(a, l, ok);
        total++;
        if (!ok || a !== 64'h0000_0001_0000_0000 || l !== 10'd48) begin
            bad++;
            $display("FAIL carry_tlp1: got ok=%0d addr=%h len=%0d required 100000000/48", ok, a, l);
        end
        count_done(5, n);
        total++;
        if (n != 1 || tlp_cnt !== 16'd2) begin
            bad++;
            $display("FAIL carry_done: got done=%0d cnt=%0d required 1/2", n, tlp_cnt);
        end
    endtask

    task automatic test_reset_midjob;
        bit ok;
        cfg_mps = 3'b000;
        start_job(64'h8000, 20'd50);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (tlp_req) ok = 1'b1;
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (!ok || tlp_req !== 1'b0 || dma_busy !== 1'b0 || tlp_cnt !== 16'd0 || tlp_addr !== 64'h0) begin
            bad++;
            $display("FAIL reset_midjob: got ok=%0d req=%b busy=%b cnt=%0d addr=%h required 1/0/0/0/0",
                     ok, tlp_req, dma_busy, tlp_cnt, tlp_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        dma_start = 1'b0;
        dma_addr  = '0;
        dma_len   = '0;
        cfg_mps   = 3'b000;
        dma_abort = 1'b0;
        tlp_last  = 1'b0;
        test_reset;
        test_mps32;
        test_4k_split;
        test_latency;
        test_ignored_starts;
        test_abort;
        test_carry;
        test_reset_midjob;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
